// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

  typedef enum int unsigned {
    RST_CLR = 0,
    RST_SET = 1,
    RST_VAL = 2
  } rst_mode_e;

  // Widest data word rst_word can build; dff_pipe rejects anything wider.
  localparam int unsigned RST_WORD_MAX = 256;

  function automatic int unsigned occ_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [RST_WORD_MAX-1:0] rst_word(int unsigned mode, int unsigned width,
                                                       logic [RST_WORD_MAX-1:0] val);
    logic [RST_WORD_MAX-1:0] w;
    w = '0;
    case (mode)
      RST_SET: begin
        for (int unsigned i = 0; i < RST_WORD_MAX; i++)
          if (i < width) w[i] = 1'b1;
      end
      RST_VAL: w = val;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One WIDTH-bit data + valid register with RESET > FLUSH > CE > hold priority.
module dff_pipe_stage #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INIT     = '0,
  parameter logic [WIDTH-1:0]  RST_WORD = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD
);

  logic [WIDTH-1:0] data = INIT;
  logic             vld  = 1'b0;

  // FLUSH only touches the valid bit; data keeps following CE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data <= RST_WORD;
      vld  <= 1'b0;
    end else begin
      if (CE)
        data <= D;
      if (FLUSH)
        vld <= 1'b0;
      else if (CE)
        vld <= D_VLD;
    end
  end

  assign Q     = data;
  assign Q_VLD = vld;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register pipeline with clock enable, reset mode and valid tracking.
// Define DFF_PIPE_OCC_EN to add the OCC valid-stage occupancy output.
module dff_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 3,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter int unsigned      RST_MODE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [dff_pipe_pkg::occ_width(DEPTH)-1:0] OCC
`endif
);

  import dff_pipe_pkg::*;

  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be at least 1");
  end
  if (RST_MODE > 2) begin : g_bad_mode
    $error("dff_pipe: RST_MODE must be 0, 1 or 2");
  end
  if (WIDTH < 1 || WIDTH > RST_WORD_MAX) begin : g_bad_width
    $error("dff_pipe: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] RST_WORD =
    WIDTH'(rst_word(RST_MODE, WIDTH, RST_WORD_MAX'(RST_VAL)));

  logic [WIDTH-1:0] data [DEPTH+1];
  logic             vld  [DEPTH+1];

  assign data[0] = D;
  assign vld[0]  = D_VLD;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_pipe_stage #(
      .WIDTH    (WIDTH),
      .INIT     (INIT),
      .RST_WORD (RST_WORD)
    ) u_stage (
      .CLK   (CLK),
      .RESET (RESET),
      .CE    (CE),
      .FLUSH (FLUSH),
      .D     (data[i]),
      .D_VLD (vld[i]),
      .Q     (data[i+1]),
      .Q_VLD (vld[i+1])
    );
  end

  assign Q     = data[DEPTH];
  assign Q_VLD = vld[DEPTH];

`ifdef DFF_PIPE_OCC_EN
  localparam int unsigned OW = occ_width(DEPTH);

  logic [OW-1:0] occ = '0;

  // Tracks valid stages incrementally: one in from D_VLD, one out via Q_VLD.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH)
      occ <= '0;
    else if (CE)
      occ <= occ + OW'(D_VLD) - OW'(Q_VLD);
  end

  assign OCC = occ;
`endif

endmodule
